spi_master: RTL



---
 rtl/spi_master.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master: serialises tx_data MSB-first on mosi and assembles miso into rx_data; frame takes (2*DATA_W+3)*CLK_DIV clk cycles.
// Backpressure: start is honoured only in IDLE; while busy it is dropped, never queued.
module spi_master #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] PHASE_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HOLD_END  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic              phase_done;
  logic              hold_done;

  assign phase_done = (div_cnt == PHASE_END);
  assign hold_done  = (div_cnt == HOLD_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            mosi     <= tx_data[DATA_W-1];
            ss       <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end
        SETUP, LOW: begin
          if (phase_done) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (phase_done) begin
            div_cnt  <= '0;
            sclk     <= 1'b0;
            rx_shift <= {rx_shift[DATA_W-2:0], miso};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              tx_shift <= tx_shift << 1;
              mosi     <= tx_shift[DATA_W-2];
              state    <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // After the last fall sclk stays low for a full low phase plus a
        // hold phase before ss is released.
        HOLD: begin
          if (hold_done) begin
            div_cnt <= '0;
            ss      <= 1'b1;
            rx_data <= rx_shift;
            done    <= 1'b1;
            mosi    <= 1'b0;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (phase_done) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
